// File: rtl/fetch.sv
// Instruction fetch stage: requests one word from instruction memory, holds it until consumed, then advances the PC.
// Optional build macro FETCH_MISALIGN_TRAP_EN traps a misaligned redirect into a sticky FAULT state.
module fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [63:0] pc_out,
    output logic [63:0] PC4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        misalign
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        FAULT = 2'd3
`endif
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [63:0] pc_r;
    logic [63:0] pc_next_s;
    logic [63:0] redirect_pc_s;
    logic [31:0] inst_r;
    logic [31:0] inst_next_s;
    logic        imem_req_r;
    logic        inst_valid_r;
    logic        misalign_r;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_pc_s = next_pc;
`else
    assign redirect_pc_s = {next_pc[63:2], 2'b00};
`endif

    // Next-state, next-PC and instruction capture; redirect only matters on a consumption edge
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        inst_next_s  = inst_r;
        case (state_r)
            IDLE: begin
                state_next_s = REQ;
            end
            REQ: begin
                if (imem_ready) begin
                    inst_next_s  = imem_rdata;
                    state_next_s = HOLD;
                end else begin
                    state_next_s = REQ;
                end
            end
            HOLD: begin
                if (!stall) begin
                    if (redirect) begin
                        pc_next_s = redirect_pc_s;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (next_pc[1:0] != 2'b00) begin
                            state_next_s = FAULT;
                        end else begin
                            state_next_s = REQ;
                        end
`else
                        state_next_s = REQ;
`endif
                    end else begin
                        pc_next_s    = pc_r + 64'd4;
                        state_next_s = REQ;
                    end
                end else begin
                    state_next_s = HOLD;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            FAULT: begin
                state_next_s = FAULT;
            end
`endif
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, PC, instruction and registered status outputs decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            inst_r       <= NOP_INST;
            imem_req_r   <= 1'b0;
            inst_valid_r <= 1'b0;
            misalign_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            pc_r         <= pc_next_s;
            inst_r       <= inst_next_s;
            imem_req_r   <= (state_next_s == REQ);
            inst_valid_r <= (state_next_s == HOLD);
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_r   <= (state_next_s == FAULT);
`else
            misalign_r   <= 1'b0;
`endif
        end
    end

    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign pc_out     = pc_r;
    assign PC4        = pc_r + 64'd4;
    assign inst       = inst_r;
    assign inst_valid = inst_valid_r;
    assign misalign   = misalign_r;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: a scoreboard queues {pc, word} on every memory handshake and compares
// it when the instruction becomes valid; a small PC model tracks the expected fetch address.
module tb_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] next_pc;
    logic        redirect;
    logic        stall;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [63:0] pc_out;
    logic [63:0] PC4;
    logic [31:0] inst;
    logic        inst_valid;
    logic        misalign;

    int          cnt_cmp = 0;
    int          cnt_err = 0;
    logic [95:0] sb_q[$];
    logic [63:0] exp_pc;
    bit          faulted;

    fetch #(.RESET_PC(64'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc    (next_pc),
        .redirect   (redirect),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .PC4        (PC4),
        .inst       (inst),
        .inst_valid (inst_valid),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cnt_cmp++;
        if (obs !== exp) begin
            cnt_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: inputs are already driven, sample at the following falling edge.
    task automatic cycle();
        bit          hs;
        bit          cons;
        logic [95:0] item;
        hs   = imem_req && imem_ready;
        cons = inst_valid && !stall;
        if (imem_req) check("req_addr", imem_addr, exp_pc);
        if (hs) sb_q.push_back({exp_pc, imem_rdata});
        @(posedge clk);
        @(negedge clk);
        if (cons) begin
            if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                exp_pc = next_pc;
                if (next_pc[1:0] != 2'b00) faulted = 1'b1;
`else
                exp_pc = {next_pc[63:2], 2'b00};
`endif
            end else begin
                exp_pc = exp_pc + 64'd4;
            end
            check("cons_req", 64'(imem_req), 64'(!faulted));
            check("cons_valid", 64'(inst_valid), 64'd0);
            check("cons_misalign", 64'(misalign), 64'(faulted));
            check("cons_pc", pc_out, exp_pc);
        end
        if (hs) begin
            item = sb_q.pop_front();
            check("cap_valid", 64'(inst_valid), 64'd1);
            check("cap_inst", 64'(inst), 64'(item[31:0]));
            check("cap_pc", pc_out, item[95:32]);
            check("cap_pc4", PC4, item[95:32] + 64'd4);
            imem_rdata = imem_rdata + 32'h0010_0000;
        end
    endtask

    task automatic consume_with(input bit r, input logic [63:0] tgt);
        int n;
        n = 0;
        while (!inst_valid && n < 10) begin
            cycle();
            n++;
        end
        check("wait_valid", 64'(inst_valid), 64'd1);
        redirect = r;
        next_pc  = tgt;
        stall    = 1'b0;
        cycle();
        redirect = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit reached expected $finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        redirect   = 1'b0;
        stall      = 1'b0;
        imem_ready = 1'b1;
        next_pc    = 64'h0;
        imem_rdata = 32'h0050_0093;
        exp_pc     = 64'h0;
        faulted    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'h13);
        check("rst_pc", pc_out, 64'h0);
        check("rst_misalign", 64'(misalign), 64'd0);

        // Release reset: IDLE then REQ at address 0, then capture with PC4 = 4
        stall = 1'b1;
        reset = 1'b0;
        cycle();
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", imem_addr, 64'h0);
        check("first_valid", 64'(inst_valid), 64'd0);
        cycle();
        check("first_inst", 64'(inst), 64'h0050_0093);
        check("first_pc4", PC4, 64'h4);

        // Stall for 5 cycles with a redirect pulse that must be ignored
        for (int i = 0; i < 5; i++) begin
            redirect = (i == 2);
            next_pc  = 64'h40;
            cycle();
            check("hold_inst", 64'(inst), 64'h0050_0093);
            check("hold_pc", pc_out, 64'h0);
            check("hold_valid", 64'(inst_valid), 64'd1);
            check("hold_req", 64'(imem_req), 64'd0);
        end
        redirect = 1'b0;
        stall    = 1'b0;
        cycle();
        check("post_stall_addr", imem_addr, 64'h4);

        // Redirect to 0x100, then from 0x100 to 0x80
        consume_with(1'b1, 64'h100);
        check("redir_addr_100", imem_addr, 64'h100);
        consume_with(1'b1, 64'h80);
        check("redir_addr_80", imem_addr, 64'h80);
        check("redir_pc4_84", PC4, 64'h84);

        // Memory withholds ready for 3 cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("wait_req", 64'(imem_req), 64'd1);
            check("wait_addr", imem_addr, 64'h80);
            check("wait_valid_lo", 64'(inst_valid), 64'd0);
        end
        imem_ready = 1'b1;
        cycle();
        consume_with(1'b0, 64'h0);
        check("seq_addr_84", imem_addr, 64'h84);

        // 64-bit wraparound
        consume_with(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        consume_with(1'b0, 64'h0);
        check("wrap_zero", imem_addr, 64'h0);
        consume_with(1'b0, 64'h0);
        check("post_wrap_addr", imem_addr, 64'h4);

        // Reset during REQ with ready asserted: immediate reset values, no capture
        check("pre_rst_req", 64'(imem_req), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_req", 64'(imem_req), 64'd0);
        check("mid_rst_pc", pc_out, 64'h0);
        check("mid_rst_inst", 64'(inst), 64'h13);
        check("mid_rst_valid", 64'(inst_valid), 64'd0);
        check("mid_rst_misalign", 64'(misalign), 64'd0);
        @(negedge clk);
        check("held_rst_inst", 64'(inst), 64'h13);
        check("held_rst_valid", 64'(inst_valid), 64'd0);
        check("held_rst_req", 64'(imem_req), 64'd0);
        reset   = 1'b0;
        exp_pc  = 64'h0;
        faulted = 1'b0;
        sb_q.delete();
        cycle();
        check("rerun_req", 64'(imem_req), 64'd1);
        cycle();

        // Misaligned redirect target 0x102
        consume_with(1'b1, 64'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("fault_misalign", 64'(misalign), 64'd1);
            check("fault_req", 64'(imem_req), 64'd0);
            check("fault_valid", 64'(inst_valid), 64'd0);
            check("fault_pc", pc_out, 64'h102);
        end
`else
        check("misalign_addr", imem_addr, 64'h100);
        check("misalign_flag", 64'(misalign), 64'd0);
        consume_with(1'b0, 64'h0);
        check("misalign_next", imem_addr, 64'h104);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_err);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, is the PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 next_pc  input  64  branch target from execute stage.
REQ-005 redirect  input  1  taken-branch indication (Branch AND zero) for the instruction being consumed.
REQ-006 stall  input  1  downstream not ready; blocks consumption of inst.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  64  read address, equals pc_out.
REQ-009 imem_ready  input  1  imem_rdata valid this cycle; may assert in the same cycle as imem_req.
REQ-010 imem_rdata  input  32  instruction word from memory.
REQ-011 pc_out  output  64  PC of the held instruction or the pending request.
REQ-012 PC4  output  64  pc_out + 4, combinational.
REQ-013 inst  output  32  registered instruction word.
REQ-014 inst_valid  output  1  inst/pc_out/PC4 valid for consumption.
REQ-015 misalign  output  1  misaligned-redirect fault flag (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, REQ, HOLD, FAULT; FAULT is only reachable when FETCH_MISALIGN_TRAP_EN is defined.
REQ-017 IDLE: imem_req=0; unconditionally to REQ on the next edge.
REQ-018 REQ: imem_req=1, imem_addr=pc_out; on edge with imem_ready=1, inst<=imem_rdata, go HOLD; otherwise stay REQ with address stable.
REQ-019 HOLD: inst_valid=1, imem_req=0; consumption occurs on an edge with inst_valid=1 and stall=0.
REQ-020 On consumption, pc_out SHALL load next_pc if redirect=1, else pc_out+4, and FSM goes REQ.
REQ-021 redirect SHALL be ignored on any edge that is not a consumption edge.
REQ-022 inst_valid SHALL be 1 only in HOLD; inst and pc_out SHALL not change while in HOLD.
REQ-023 PC arithmetic SHALL be 64-bit modulo 2^64; pc 64'hFFFF_FFFF_FFFF_FFFC plus 4 wraps to 0.
REQ-024 Minimum latency: request-to-inst_valid 1 cycle with imem_ready in the request cycle; steady throughput 1 instruction per 2 cycles.
REQ-025 imem_ready asserted outside REQ SHALL be ignored.

Reset
REQ-026 Asserting reset SHALL immediately force FSM=IDLE, pc_out=RESET_PC, inst=32'h00000013, inst_valid=0, imem_req=0, misalign=0.
REQ-027 Reset mid-request SHALL abandon the request; any imem_ready during reset is ignored.
REQ-028 First imem_req SHALL assert in the second cycle after reset deasserts (IDLE then REQ).

Configuration
REQ-029 Macro FETCH_MISALIGN_TRAP_EN defined: a consumed redirect with next_pc[1:0]!=0 SHALL load pc_out=next_pc, go FAULT, set misalign=1; FAULT holds imem_req=0, inst_valid=0 until reset.
REQ-030 Macro undefined: next_pc[1:0] SHALL be forced to 2'b00 on redirect load; misalign tied 0; FAULT absent.

Verification
REQ-031 Reset release, RESET_PC=0, imem_ready=1 always, rdata=32'h00500093 -> imem_req cycle 2 addr 0; inst_valid cycle 3, inst=32'h00500093, PC4=4.
REQ-032 HOLD with stall=1 for 5 cycles, redirect=1 pulsed mid-stall -> inst, pc_out unchanged; after stall drops with redirect=0, next addr = pc_out+4.
REQ-033 Consume at pc=64'h100 with redirect=1, next_pc=64'h80 -> next imem_addr=64'h80; PC4=64'h84.
REQ-034 imem_ready withheld 3 cycles in REQ -> imem_req and imem_addr stable all 3 cycles; inst_valid rises edge after ready.
REQ-035 Redirect next_pc=64'h102: macro defined -> misalign=1, imem_req=0 permanently until reset; undefined -> imem_addr=64'h100.
REQ-036 Reset asserted during REQ with imem_ready=1 -> outputs at reset values immediately; no inst capture.
